// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch sequencer.
package fetch_pkg;

  localparam int WADDR_W = 30;

  localparam logic [WADDR_W-1:0] RESET_VEC_DFLT = 30'h0040_0000;
  localparam logic [WADDR_W-1:0] TRAP_VEC_DFLT  = 30'h0000_0001;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_OUT  = 3'd3,
    ST_DROP = 3'd4
  } fetch_state_e;

  // Word-address increment; wraps naturally modulo 2^WADDR_W.
  function automatic logic [WADDR_W-1:0] pc_inc(input logic [WADDR_W-1:0] pc);
    return pc + {{(WADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// Holding register for the instruction handed to decode (if_instr/if_pc/if_valid).
module fetch_out_buf
  import fetch_pkg::*;
#(
  parameter logic [WADDR_W-1:0] RESET_VEC = RESET_VEC_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_pc_load,
  input  logic [WADDR_W-1:0] i_pc,
  input  logic               i_instr_load,
  input  logic [31:0]        i_instr,
  input  logic               i_clr,
  output logic               o_valid,
  output logic [31:0]        o_instr,
  output logic [WADDR_W-1:0] o_pc
);

  logic               r_valid;
  logic [31:0]        r_instr;
  logic [WADDR_W-1:0] r_pc;

  // if_pc is captured at request acceptance so it is ready when the word lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= RESET_VEC;
    end else begin
      if (i_pc_load) begin
        r_pc <= i_pc;
      end
      if (i_instr_load) begin
        r_instr <= i_instr;
        r_valid <= 1'b1;
      end else if (i_clr) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer with redirect handling.
// Optional trap input enabled by defining FETCH_TRAP_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [WADDR_W-1:0] RESET_VEC = RESET_VEC_DFLT
`ifdef FETCH_TRAP_EN
  ,
  parameter logic [WADDR_W-1:0] TRAP_VEC  = TRAP_VEC_DFLT
`endif
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:2] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:2] if_pc,
  input  logic        redirect,
  input  logic [31:2] redirect_target
`ifdef FETCH_TRAP_EN
  ,
  input  logic        trap
`endif
);

  fetch_state_e       r_state;
  logic [WADDR_W-1:0] r_pc;
  logic               r_req_valid;

  logic               w_redir;
  logic [WADDR_W-1:0] w_redir_tgt;
  logic [WADDR_W-1:0] w_pc_next;
  logic               w_accept;
  logic               w_pc_load;
  logic               w_instr_load;
  logic               w_clr;
  logic [WADDR_W-1:0] w_if_pc;

`ifdef FETCH_TRAP_EN
  assign w_redir     = trap | redirect;
  assign w_redir_tgt = trap ? TRAP_VEC : redirect_target;
`else
  assign w_redir     = redirect;
  assign w_redir_tgt = redirect_target;
`endif

  assign w_pc_next    = pc_inc(r_pc);
  assign w_accept     = (r_state == ST_REQ) && imem_req_ready;
  assign w_pc_load    = w_accept && !w_redir;
  assign w_instr_load = (r_state == ST_WAIT) && imem_rsp_valid && !w_redir;
  assign w_clr        = (r_state == ST_OUT) && (if_ready || w_redir);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_VEC;
      r_req_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_redir) begin
            r_pc <= w_redir_tgt;
          end
          r_state     <= ST_REQ;
          r_req_valid <= 1'b1;
        end
        ST_REQ: begin
          if (w_redir) begin
            r_pc <= w_redir_tgt;
            if (imem_req_ready) begin
              r_state     <= ST_DROP;
              r_req_valid <= 1'b0;
            end
          end else if (imem_req_ready) begin
            r_pc        <= w_pc_next;
            r_state     <= ST_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (w_redir) begin
            r_pc    <= w_redir_tgt;
            r_state <= ST_DROP;
          end else if (imem_rsp_valid) begin
            r_state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (w_redir || if_ready) begin
            if (w_redir) begin
              r_pc <= w_redir_tgt;
            end
            r_state     <= ST_REQ;
            r_req_valid <= 1'b1;
          end
        end
        ST_DROP: begin
          if (w_redir) begin
            r_pc <= w_redir_tgt;
          end
          // The stale response is the only one outstanding, so it is consumed
          // even when a redirect lands on the same cycle; waiting would deadlock.
          if (imem_rsp_valid) begin
            r_state     <= ST_REQ;
            r_req_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  fetch_out_buf #(
    .RESET_VEC (RESET_VEC)
  ) u_out_buf (
    .clk          (clk),
    .rst          (rst),
    .i_pc_load    (w_pc_load),
    .i_pc         (r_pc),
    .i_instr_load (w_instr_load),
    .i_instr      (imem_rsp_data),
    .i_clr        (w_clr),
    .o_valid      (if_valid),
    .o_instr      (if_instr),
    .o_pc         (w_if_pc)
  );

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign if_pc          = w_if_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table-driven bench for fetch_sequencer (trap case with FETCH_TRAP_EN).
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:2] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:2] if_pc;
  logic        redirect = 1'b0;
  logic [31:2] redirect_target = '0;
`ifdef FETCH_TRAP_EN
  logic        trap = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .redirect        (redirect),
    .redirect_target (redirect_target)
`ifdef FETCH_TRAP_EN
    ,
    .trap            (trap)
`endif
  );

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] d;
    logic        ifr;
    logic        rd;
    logic [29:0] t;
    logic        e_rv;
    logic [29:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [29:0] e_pc;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] d,
                              input logic ifr, input logic rd, input logic [29:0] t,
                              input logic e_rv, input logic [29:0] e_addr, input logic e_iv,
                              input logic [31:0] e_instr, input logic [29:0] e_pc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.d = d; v.ifr = ifr; v.rd = rd; v.t = t;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_instr = e_instr; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [31:0] d,
                      input logic ifr, input logic rd, input logic [29:0] t);
    @(negedge clk);
    imem_req_ready  = rdy;
    imem_rsp_valid  = rv;
    imem_rsp_data   = d;
    if_ready        = ifr;
    redirect        = rd;
    redirect_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic e_rv, input logic [29:0] e_addr,
                         input logic e_iv, input logic [31:0] e_instr, input logic [29:0] e_pc);
    chk({nm, "_req_valid"}, {31'd0, imem_req_valid}, {31'd0, e_rv});
    chk({nm, "_req_addr"}, {2'b00, imem_req_addr}, {2'b00, e_addr});
    chk({nm, "_if_valid"}, {31'd0, if_valid}, {31'd0, e_iv});
    if (e_iv) begin
      chk({nm, "_if_instr"}, if_instr, e_instr);
      chk({nm, "_if_pc"}, {2'b00, if_pc}, {2'b00, e_pc});
    end
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 32'h0,         0, 0, 30'h0,         1, 30'h0040_0000, 0, 32'h0, 30'h0);
    tbl[1]  = mk(1, 0, 32'h0,         0, 0, 30'h0,         0, 30'h0040_0001, 0, 32'h0, 30'h0);
    tbl[2]  = mk(0, 1, 32'hA000_0001, 0, 0, 30'h0,         0, 30'h0040_0001, 1, 32'hA000_0001, 30'h0040_0000);
    tbl[3]  = mk(0, 0, 32'h0,         1, 0, 30'h0,         1, 30'h0040_0001, 0, 32'h0, 30'h0);
    tbl[4]  = mk(1, 0, 32'h0,         0, 0, 30'h0,         0, 30'h0040_0002, 0, 32'h0, 30'h0);
    tbl[5]  = mk(0, 1, 32'hB000_0002, 0, 0, 30'h0,         0, 30'h0040_0002, 1, 32'hB000_0002, 30'h0040_0001);
    for (int i = 6; i <= 10; i++)
      tbl[i] = mk(1, 0, 32'h0,        0, 0, 30'h0,         0, 30'h0040_0002, 1, 32'hB000_0002, 30'h0040_0001);
    tbl[11] = mk(0, 0, 32'h0,         1, 0, 30'h0,         1, 30'h0040_0002, 0, 32'h0, 30'h0);
    tbl[12] = mk(0, 0, 32'h0,         0, 0, 30'h0,         1, 30'h0040_0002, 0, 32'h0, 30'h0);
    tbl[13] = mk(1, 0, 32'h0,         0, 0, 30'h0,         0, 30'h0040_0003, 0, 32'h0, 30'h0);
    tbl[14] = mk(0, 0, 32'h0,         0, 1, 30'h0000_0100, 0, 30'h0000_0100, 0, 32'h0, 30'h0);
    tbl[15] = mk(0, 1, 32'hDEAD_0003, 0, 0, 30'h0,         1, 30'h0000_0100, 0, 32'h0, 30'h0);
    tbl[16] = mk(1, 0, 32'h0,         0, 0, 30'h0,         0, 30'h0000_0101, 0, 32'h0, 30'h0);
    tbl[17] = mk(0, 1, 32'hC000_0100, 0, 0, 30'h0,         0, 30'h0000_0101, 1, 32'hC000_0100, 30'h0000_0100);
    tbl[18] = mk(0, 0, 32'h0,         1, 1, 30'h3FFF_FFFF, 1, 30'h3FFF_FFFF, 0, 32'h0, 30'h0);
    tbl[19] = mk(1, 0, 32'h0,         0, 0, 30'h0,         0, 30'h0000_0000, 0, 32'h0, 30'h0);
    tbl[20] = mk(0, 1, 32'hD000_0000, 0, 0, 30'h0,         0, 30'h0000_0000, 1, 32'hD000_0000, 30'h3FFF_FFFF);
    tbl[21] = mk(0, 0, 32'h0,         1, 1, 30'h0000_0200, 1, 30'h0000_0200, 0, 32'h0, 30'h0);
    tbl[22] = mk(0, 0, 32'h0,         0, 1, 30'h0000_0300, 1, 30'h0000_0300, 0, 32'h0, 30'h0);
    tbl[23] = mk(1, 0, 32'h0,         0, 1, 30'h0000_0400, 0, 30'h0000_0400, 0, 32'h0, 30'h0);
    tbl[24] = mk(0, 1, 32'h5A5A_5A5A, 0, 0, 30'h0,         1, 30'h0000_0400, 0, 32'h0, 30'h0);
    tbl[25] = mk(1, 0, 32'h0,         0, 0, 30'h0,         0, 30'h0000_0401, 0, 32'h0, 30'h0);
    tbl[26] = mk(0, 0, 32'h0,         0, 0, 30'h0,         0, 30'h0000_0401, 0, 32'h0, 30'h0);
    tbl[27] = mk(0, 1, 32'hE000_0400, 0, 0, 30'h0,         0, 30'h0000_0401, 1, 32'hE000_0400, 30'h0000_0400);
    tbl[28] = mk(0, 0, 32'h0,         0, 1, 30'h0000_0050, 1, 30'h0000_0050, 0, 32'h0, 30'h0);

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", {2'b00, imem_req_addr}, 32'h0040_0000);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", {2'b00, if_pc}, 32'h0040_0000);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].rdy, tbl[i].rv, tbl[i].d, tbl[i].ifr, tbl[i].rd, tbl[i].t);
      chk_out($sformatf("v%0d", i), tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_iv,
              tbl[i].e_instr, tbl[i].e_pc);
    end

    // Reset asserted asynchronously while a request is outstanding.
    step(1, 0, 32'h0, 0, 0, 30'h0);
    chk_out("mr_wait", 0, 30'h0000_0051, 0, 32'h0, 30'h0);
    @(negedge clk);
    imem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_out("mr_async", 0, 30'h0040_0000, 0, 32'h0, 30'h0);
    chk("mr_async_if_pc", {2'b00, if_pc}, 32'h0040_0000);
    @(posedge clk);
    #1 rst = 1'b0;
    step(0, 1, 32'hBAD0_BAD0, 0, 0, 30'h0);
    chk_out("mr_idle_rsp", 1, 30'h0040_0000, 0, 32'h0, 30'h0);
    step(1, 0, 32'h0, 0, 0, 30'h0);
    chk_out("mr_req", 0, 30'h0040_0001, 0, 32'h0, 30'h0);
    step(0, 0, 32'h0, 0, 0, 30'h0);
    chk_out("mr_wait2", 0, 30'h0040_0001, 0, 32'h0, 30'h0);
    step(0, 1, 32'hF000_000F, 0, 0, 30'h0);
    chk_out("mr_out", 0, 30'h0040_0001, 1, 32'hF000_000F, 30'h0040_0000);

`ifdef FETCH_TRAP_EN
    @(negedge clk);
    imem_rsp_valid  = 1'b0;
    trap            = 1'b1;
    redirect        = 1'b1;
    redirect_target = 30'h0000_0200;
    @(posedge clk);
    #1;
    chk_out("trap_win", 1, 30'h0000_0001, 0, 32'h0, 30'h0);
    @(negedge clk);
    trap     = 1'b0;
    redirect = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
